// File: rtl/apu_frame_pkg.sv
// Shared constants and types for the APU frame sequencer: step counts,
// sequence-mode encoding and bit positions of the step-hit vector.
package apu_frame_pkg;

  localparam int unsigned CNT_W = 15;

  localparam logic [CNT_W-1:0] STEP1 = 15'd3728;
  localparam logic [CNT_W-1:0] STEP2 = 15'd7456;
  localparam logic [CNT_W-1:0] STEP3 = 15'd11185;
  localparam logic [CNT_W-1:0] STEP4 = 15'd14914;
  localparam logic [CNT_W-1:0] STEP5 = 15'd18640;

  typedef enum logic {
    FRAME_MODE_4STEP = 1'b0,
    FRAME_MODE_5STEP = 1'b1
  } frame_mode_e;

  // Step-hit vector layout: {quarter, half, irq, wrap}
  localparam int unsigned HIT_W    = 4;
  localparam int unsigned HIT_Q    = 3;
  localparam int unsigned HIT_H    = 2;
  localparam int unsigned HIT_IRQ  = 1;
  localparam int unsigned HIT_WRAP = 0;

endpackage

// File: rtl/apu_frame_step_decode.sv
// Decodes the count the sequencer is about to take into the strobe, IRQ and
// wrap events that belong to that step in the current sequence mode.
module apu_frame_step_decode
  import apu_frame_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_next,
  input  frame_mode_e      mode,
  output logic [HIT_W-1:0] hits
);

  always_comb begin
    hits = '0;
    if (cnt_next == STEP1 || cnt_next == STEP3) begin
      hits[HIT_Q] = 1'b1;
    end
    if (cnt_next == STEP2) begin
      hits[HIT_Q] = 1'b1;
      hits[HIT_H] = 1'b1;
    end
    if (mode == FRAME_MODE_4STEP) begin
      if (cnt_next == STEP4) begin
        hits[HIT_Q]    = 1'b1;
        hits[HIT_H]    = 1'b1;
        hits[HIT_IRQ]  = 1'b1;
        hits[HIT_WRAP] = 1'b1;
      end
    end else if (cnt_next == STEP5) begin
      // STEP4 is silent in 5-step mode; the final step never raises IRQ
      hits[HIT_Q]    = 1'b1;
      hits[HIT_H]    = 1'b1;
      hits[HIT_WRAP] = 1'b1;
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: $4017 mode/IRQ-inhibit register, step counter,
// registered quarter/half-frame strobes and the frame interrupt flag.
module apu_frame_counter
  import apu_frame_pkg::*;
(
  input  logic       ACLK1,
  input  logic       RES,
  input  logic       WR4017,
  input  logic [7:0] DB,
  input  logic       R4015,
  output logic       nLFO1,
  output logic       nLFO2,
  output logic       FRAME_INT,
  output logic       MODE
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [HIT_W-1:0] hits;
  logic             at_wrap;
  logic             irq_inh;
  logic             wr_pend;
  logic             irq_set;
  logic             unused_db;
  frame_mode_e      mode;

  // at_wrap remembers that cnt sits on the wrap point, so the next edge loads 0
  assign cnt_next  = at_wrap ? '0 : cnt + 1'b1;
  assign irq_set   = hits[HIT_IRQ] && !irq_inh;
  assign MODE      = mode;
  assign unused_db = ^DB[5:0];

  apu_frame_step_decode u_step_decode (
    .cnt_next (cnt_next),
    .mode     (mode),
    .hits     (hits)
  );

  always_ff @(posedge ACLK1 or posedge RES) begin
    if (RES) begin
      cnt       <= '0;
      at_wrap   <= 1'b0;
      mode      <= FRAME_MODE_4STEP;
      irq_inh   <= 1'b0;
      wr_pend   <= 1'b0;
      FRAME_INT <= 1'b0;
      nLFO1     <= 1'b1;
      nLFO2     <= 1'b1;
    end else if (WR4017) begin
      // A write overrides any step hit on this edge, but an already
      // pending immediate strobe still fires.
      cnt     <= '0;
      at_wrap <= 1'b0;
      mode    <= frame_mode_e'(DB[7]);
      irq_inh <= DB[6];
      wr_pend <= DB[7];
      nLFO1   <= ~wr_pend;
      nLFO2   <= ~wr_pend;
      if (DB[6] || R4015) begin
        FRAME_INT <= 1'b0;
      end
    end else begin
      cnt     <= cnt_next;
      at_wrap <= hits[HIT_WRAP];
      wr_pend <= 1'b0;
      nLFO1   <= ~(hits[HIT_Q] | wr_pend);
      nLFO2   <= ~(hits[HIT_H] | wr_pend);
      if (irq_set) begin
        FRAME_INT <= 1'b1;
      end else if (R4015) begin
        FRAME_INT <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK1) begin
    if (!RES) begin
      assert (cnt <= STEP5);
      assert (mode == FRAME_MODE_5STEP || cnt <= STEP4);
    end
  end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Self-checking bench for apu_frame_counter: directed sequence with random
// bus noise and R4015 pulses, compared every cycle to a step-rule model.
module tb_apu_frame_counter;

  logic       aclk1 = 1'b0;
  logic       res;
  logic       wr4017;
  logic [7:0] db;
  logic       r4015;
  logic       nlfo1;
  logic       nlfo2;
  logic       frame_int;
  logic       mode;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc    = 0;

  // reference model state
  int m_cnt;
  bit m_mode, m_inh, m_int, m_pend, e_n1, e_n2;

  apu_frame_counter dut (
    .ACLK1     (aclk1),
    .RES       (res),
    .WR4017    (wr4017),
    .DB        (db),
    .R4015     (r4015),
    .nLFO1     (nlfo1),
    .nLFO2     (nlfo2),
    .FRAME_INT (frame_int),
    .MODE      (mode)
  );

  always #5 aclk1 = ~aclk1;

  function automatic bit quarter_at(int c, bit m);
    return (c == 3728) || (c == 7456) || (c == 11185) || (c == (m ? 18640 : 14914));
  endfunction

  function automatic bit half_at(int c, bit m);
    return (c == 7456) || (c == (m ? 18640 : 14914));
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_inh = 0; m_int = 0; m_pend = 0; e_n1 = 1; e_n2 = 1;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic rd);
    int nc;
    if (wr) begin
      e_n1 = !m_pend;
      e_n2 = !m_pend;
      if (d[6] || rd) m_int = 0;
      m_mode = d[7];
      m_inh  = d[6];
      m_pend = d[7];
      m_cnt  = 0;
    end else begin
      nc   = (m_cnt + 1) % (m_mode ? 18641 : 14915);
      e_n1 = !(m_pend || quarter_at(nc, m_mode));
      e_n2 = !(m_pend || half_at(nc, m_mode));
      if (!m_mode && nc == 14914 && !m_inh) m_int = 1;
      else if (rd) m_int = 0;
      m_pend = 0;
      m_cnt  = nc;
    end
  endtask

  function automatic logic [3:0] dut_vec();
    return {nlfo1, nlfo2, frame_int, mode};
  endfunction

  function automatic logic [3:0] model_vec();
    return {e_n1, e_n2, m_int, m_mode};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at cycle %0d: observed %b, expected %b", tag, cyc, obs, exp);
    if (checks - passed >= 25) begin
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  endtask

  task automatic expect1(input string tag, input logic obs, input logic exp);
    check(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    wr4017 = wr;
    db     = d;
    r4015  = rd;
    @(posedge aclk1);
    model_edge(wr, d, rd);
    #1;
    cyc++;
    check("seq", dut_vec(), model_vec());
    wr4017 = 1'b0;
    r4015  = 1'b0;
  endtask

  task automatic run(input int n, input bit rd_ok);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), rd_ok && ($urandom_range(63) == 0));
    end
  endtask

  initial begin
    res = 1'b1; wr4017 = 1'b0; db = 8'h00; r4015 = 1'b0;
    model_reset();
    #2 check("reset_state", dut_vec(), 4'b1100);
    #10 res = 1'b0;

    // Reset mid-sequence at count 9000
    run(9000, 1'b1);
    #1 res = 1'b1;
    #1 check("async_reset", dut_vec(), 4'b1100);
    model_reset();
    repeat (3) @(posedge aclk1);
    #2 res = 1'b0;

    // 4-step run from release; R4015 coincides with the STEP4 hit
    run(3727, 1'b1);
    expect1("no_q_3727", nlfo1, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    expect1("q_3728_after_release", nlfo1, 1'b0);
    expect1("no_h_3728", nlfo2, 1'b1);
    run(3727, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("qh_7456", dut_vec(), 4'b0000);
    run(7457, 1'b1);
    step(1'b0, 8'($urandom), 1'b1);
    check("set_wins_14914", dut_vec(), 4'b0010);
    step(1'b0, 8'($urandom), 1'b0);
    check("wrap_to_0", dut_vec(), 4'b1110);

    // Inhibit write on the 7456 hit while FRAME_INT is set
    run(7455, 1'b0);
    expect1("int_held", frame_int, 1'b1);
    step(1'b1, {2'b01, 6'($urandom)}, 1'b0);
    check("write_on_hit", dut_vec(), 4'b1100);
    run(3727, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("q_3728_after_write", dut_vec(), 4'b0100);
    run(11185, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("inhibit_no_set", dut_vec(), 4'b0000);

    // Natural set, then an R4015 pulse clears it
    step(1'b1, {2'b00, 6'($urandom)}, 1'b0);
    run(14913, 1'b0);
    step(1'b0, 8'($urandom), 1'b0);
    check("natural_set", dut_vec(), 4'b0010);
    run(4, 1'b0);
    expect1("int_before_read", frame_int, 1'b1);
    step(1'b0, 8'($urandom), 1'b1);
    expect1("r4015_clear", frame_int, 1'b0);

    // Back-to-back writes: pending strobe survives the second write
    step(1'b1, {2'b10, 6'($urandom)}, 1'b0);
    check("b2b_first", dut_vec(), 4'b1101);
    step(1'b1, {2'b00, 6'($urandom)}, 1'b0);
    check("pend_survives_write", dut_vec(), 4'b0000);
    step(1'b0, 8'($urandom), 1'b0);
    check("mode0_write_no_strobe", dut_vec(), 4'b1100);

    // 5-step mode over two full periods
    step(1'b1, {2'b10, 6'($urandom)}, 1'b0);
    check("write_5step", dut_vec(), 4'b1101);
    step(1'b0, 8'($urandom), 1'b0);
    check("immediate_strobe", dut_vec(), 4'b0001);
    step(1'b0, 8'($urandom), 1'b0);
    check("immediate_strobe_end", dut_vec(), 4'b1101);
    run(14911, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("silent_14914_5step", dut_vec(), 4'b1101);
    run(3725, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("qh_18640_p1", dut_vec(), 4'b0001);
    step(1'b0, 8'($urandom), 1'b0);
    check("wrap_5step_p1", dut_vec(), 4'b1101);
    run(18639, 1'b1);
    step(1'b0, 8'($urandom), 1'b0);
    check("qh_18640_p2", dut_vec(), 4'b0001);
    step(1'b0, 8'($urandom), 1'b0);
    check("wrap_5step_p2", dut_vec(), 4'b1101);

    // Random writes and status reads
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(15) == 0, 8'($urandom), $urandom_range(7) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
